// File: rtl/nock_execute_if.sv
// Memory bus between the Nock execution unit (master) and cell memory (slave).
// One-cycle request strobe; mem_ready doubles as idle and read-data-valid.
interface nock_execute_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64
);
    logic              mem_execute;
    logic [1:0]        mem_func;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              mem_ready;
    logic [DATA_W-1:0] read_data;
    logic [ADDR_W-1:0] free_addr;

    modport master (
        output mem_execute, mem_func, address, write_data,
        input  mem_ready, read_data, free_addr
    );

    modport slave (
        input  mem_execute, mem_func, address, write_data,
        output mem_ready, read_data, free_addr
    );
endinterface

// File: rtl/nock_execute.sv
// Nock execution module: evaluates *[subject formula] for opcodes 0 (slot) and 1 (constant)
// and writes the result back into the originating cell, or reports an error code.
module nock_execute #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 64,
    parameter logic [3:0]  RET_SYS_FUNC = 4'h1,
    parameter logic [3:0]  RET_STATE    = 4'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              execute_start,
    input  logic [ADDR_W-1:0] execute_address,
    input  logic [7:0]        execute_tag,
    input  logic [DATA_W-1:0] execute_data,
    nock_execute_if.master    bus,
    output logic              finished,
    output logic [7:0]        error,
    output logic [3:0]        execute_return_sys_func,
    output logic [3:0]        execute_return_state
);
    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_FETCH      = 4'd1;
    localparam logic [3:0] ST_WAIT_F     = 4'd2;
    localparam logic [3:0] ST_SLOT       = 4'd3;
    localparam logic [3:0] ST_SLOT_WAIT  = 4'd4;
    localparam logic [3:0] ST_WRITE      = 4'd5;
    localparam logic [3:0] ST_WRITE_WAIT = 4'd6;
    localparam logic [3:0] ST_FIN        = 4'd7;
    localparam logic [3:0] ST_DONE       = 4'd8;

    localparam logic [1:0] FUNC_READ  = 2'd0;
    localparam logic [1:0] FUNC_WRITE = 2'd1;

    logic [3:0]        r_state;
    logic [ADDR_W-1:0] r_cell_addr;
    logic [ADDR_W-1:0] r_form_ptr;
    logic [27:0]       r_subj;
    logic              r_subj_atom;
    logic [27:0]       r_res;
    logic              r_res_atom;
    logic [27:0]       r_axis;
    logic [4:0]        r_idx;
    logic              r_skip;
    logic              r_mem_execute;
    logic [1:0]        r_mem_func;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_write_data;
    logic              r_finished;
    logic [7:0]        r_error;
    logic [3:0]        r_sys_func;
    logic [3:0]        r_ret_state;

    logic [7:0]  w_f_tag;
    logic [27:0] w_f_head;
    logic [27:0] w_f_tail;
    logic [4:0]  w_msb;
    logic        w_rd_ok;
    logic        w_unused;

    assign w_f_tag  = bus.read_data[63:56];
    assign w_f_head = bus.read_data[55:28];
    assign w_f_tail = bus.read_data[27:0];

    // Response is only trusted after the strobe cycle and one skip cycle have passed.
    assign w_rd_ok = !r_mem_execute && !r_skip && bus.mem_ready;

    always_comb begin
        w_msb = 5'd0;
        for (int i = 0; i < 28; i++) begin
            if (w_f_tail[i]) w_msb = 5'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cell_addr   <= '0;
            r_form_ptr    <= '0;
            r_subj        <= '0;
            r_subj_atom   <= 1'b0;
            r_res         <= '0;
            r_res_atom    <= 1'b0;
            r_axis        <= '0;
            r_idx         <= '0;
            r_skip        <= 1'b0;
            r_mem_execute <= 1'b0;
            r_mem_func    <= FUNC_READ;
            r_address     <= '0;
            r_write_data  <= '0;
            r_finished    <= 1'b0;
            r_error       <= '0;
            r_sys_func    <= '0;
            r_ret_state   <= '0;
        end else begin
            r_mem_execute <= 1'b0;
            r_mem_func    <= FUNC_READ;
            r_address     <= '0;
            r_write_data  <= '0;
            if (r_skip && !r_mem_execute) r_skip <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (execute_start) begin
                        r_cell_addr <= execute_address;
                        r_form_ptr  <= execute_data[ADDR_W-1:0];
                        r_subj      <= execute_data[55:28];
                        r_subj_atom <= execute_tag[1];
                        r_error     <= '0;
                        r_sys_func  <= '0;
                        r_ret_state <= '0;
                        if (execute_tag[0]) begin
                            r_error <= 8'd1;
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        r_mem_execute <= 1'b1;
                        r_address     <= r_form_ptr;
                        r_skip        <= 1'b1;
                        r_state       <= ST_WAIT_F;
                    end
                end
                ST_WAIT_F: begin
                    if (w_rd_ok) begin
                        if (!w_f_tag[1]) begin
                            r_error <= 8'd1;
                            r_state <= ST_FIN;
                        end else if (w_f_head == 28'd1) begin
                            r_res      <= w_f_tail;
                            r_res_atom <= w_f_tag[0];
                            r_state    <= ST_WRITE;
                        end else if (w_f_head == 28'd0) begin
                            if (!w_f_tag[0] || w_f_tail == 28'd0) begin
                                r_error <= 8'd3;
                                r_state <= ST_FIN;
                            end else begin
                                r_res      <= r_subj;
                                r_res_atom <= r_subj_atom;
                                r_axis     <= w_f_tail;
                                r_idx      <= w_msb - 5'd1;
                                r_state    <= (w_f_tail == 28'd1) ? ST_WRITE : ST_SLOT;
                            end
                        end else begin
                            r_error <= 8'd2;
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_SLOT: begin
                    if (r_res_atom) begin
                        r_error <= 8'd3;
                        r_state <= ST_FIN;
                    end else if (bus.mem_ready) begin
                        r_mem_execute <= 1'b1;
                        r_address     <= r_res[ADDR_W-1:0];
                        r_skip        <= 1'b1;
                        r_state       <= ST_SLOT_WAIT;
                    end
                end
                ST_SLOT_WAIT: begin
                    if (w_rd_ok) begin
                        // Axis bit 0 selects the head, 1 selects the tail.
                        if (r_axis[r_idx]) begin
                            r_res      <= w_f_tail;
                            r_res_atom <= w_f_tag[0];
                        end else begin
                            r_res      <= w_f_head;
                            r_res_atom <= w_f_tag[1];
                        end
                        if (r_idx == 5'd0) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_idx   <= r_idx - 5'd1;
                            r_state <= ST_SLOT;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ready) begin
                        r_mem_execute <= 1'b1;
                        r_mem_func    <= FUNC_WRITE;
                        r_address     <= r_cell_addr;
                        r_write_data  <= {6'b100000, r_res_atom, 1'b0, r_res, 28'd0};
                        r_skip        <= 1'b1;
                        r_state       <= ST_WRITE_WAIT;
                    end
                end
                ST_WRITE_WAIT: begin
                    if (w_rd_ok) r_state <= ST_FIN;
                end
                ST_FIN: begin
                    r_finished  <= 1'b1;
                    r_sys_func  <= (r_error == 8'd0) ? RET_SYS_FUNC : 4'hF;
                    r_ret_state <= (r_error == 8'd0) ? RET_STATE : 4'h0;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_finished <= 1'b0;
                    if (!execute_start) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_execute          = r_mem_execute;
    assign bus.mem_func             = r_mem_func;
    assign bus.address              = r_address;
    assign bus.write_data           = r_write_data;
    assign finished                 = r_finished;
    assign error                    = r_error;
    assign execute_return_sys_func  = r_sys_func;
    assign execute_return_state     = r_ret_state;

    // free_addr is reserved for allocating opcodes; tag/upper pointer bits are not needed here.
    assign w_unused = ^{bus.free_addr, execute_data[63:56], execute_data[27:ADDR_W]};
endmodule

// File: tb/tb_nock_execute.sv
// Self-checking bench for nock_execute: directed scenarios plus randomized trees checked
// against a recursive-descent Nock slot/constant model over a behavioural memory.
module tb_nock_execute;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              execute_start;
    logic [ADDR_W-1:0] execute_address;
    logic [7:0]        execute_tag;
    logic [DATA_W-1:0] execute_data;
    logic              finished;
    logic [7:0]        error;
    logic [3:0]        ret_sysf;
    logic [3:0]        ret_state;

    nock_execute_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    nock_execute #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RET_SYS_FUNC(4'h1), .RET_STATE(4'h0)
    ) dut (
        .clk(clk), .rst(rst), .execute_start(execute_start),
        .execute_address(execute_address), .execute_tag(execute_tag),
        .execute_data(execute_data), .bus(bus), .finished(finished), .error(error),
        .execute_return_sys_func(ret_sysf), .execute_return_state(ret_state)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:1023];
    int n_checks, n_fail;
    int n_reads, n_writes, n_proto, lat_extra;
    int rd_log [0:8191];

    // Memory responder: strobe seen -> busy for 1+lat_extra cycles -> ready with data.
    logic              pend;
    int                pend_cnt;
    logic [1:0]        pend_func;
    logic [ADDR_W-1:0] pend_addr;
    logic [63:0]       pend_wdata;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            bus.mem_ready = 1'b1;
            bus.read_data = '0;
        end else begin
            if (bus.mem_execute && (pend || !bus.mem_ready)) n_proto++;
            if (pend) begin
                if (pend_cnt > 0) pend_cnt--;
                else begin
                    if (pend_func == 2'd0) bus.read_data = mem[pend_addr];
                    else begin
                        mem[pend_addr] = pend_wdata;
                        n_writes++;
                    end
                    bus.mem_ready = 1'b1;
                    pend = 1'b0;
                end
            end else if (bus.mem_execute) begin
                pend = 1'b1;
                pend_cnt = lat_extra;
                pend_func = bus.mem_func;
                pend_addr = bus.address;
                pend_wdata = bus.write_data;
                bus.mem_ready = 1'b0;
                if (bus.mem_func == 2'd0) begin
                    rd_log[n_reads % 8192] = int'(bus.address);
                    n_reads++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [93:0] outs();
        return {bus.mem_execute, bus.mem_func, bus.address, bus.write_data,
                finished, error, ret_sysf, ret_state};
    endfunction

    // Reference: Nock *[subject formula] for opcodes 0/1, straight from the reduction rules.
    task automatic ref_model(input logic [7:0] tag, input logic [63:0] data, output int err,
                             output logic [63:0] word, output int reads);
        logic [63:0] f;
        logic [63:0] n;
        logic [27:0] res;
        logic        res_atom;
        logic [27:0] axis;
        int          path[$];
        err = 0;
        reads = 0;
        word = '0;
        res = '0;
        res_atom = 1'b0;
        if (tag[0]) begin
            err = 1;
            return;
        end
        f = mem[data[ADDR_W-1:0]];
        reads = 1;
        if (!f[57]) err = 1;
        else if (f[55:28] == 28'd1) begin
            res = f[27:0];
            res_atom = f[56];
        end else if (f[55:28] == 28'd0) begin
            if (!f[56] || f[27:0] == 28'd0) err = 3;
            else begin
                axis = f[27:0];
                res = data[55:28];
                res_atom = tag[1];
                while (axis > 28'd1) begin
                    path.push_front(int'(axis % 28'd2));
                    axis = axis / 28'd2;
                end
                for (int i = 0; i < path.size(); i++) begin
                    if (err == 0) begin
                        if (res_atom) err = 3;
                        else begin
                            n = mem[res[ADDR_W-1:0]];
                            reads++;
                            if (path[i] == 0) begin
                                res = n[55:28];
                                res_atom = n[57];
                            end else begin
                                res = n[27:0];
                                res_atom = n[56];
                            end
                        end
                    end
                end
            end
        end else err = 2;
        if (err == 0) word = {8'h80 | (res_atom ? 8'h02 : 8'h00), res, 28'd0};
    endtask

    logic [7:0] o_err;
    logic [3:0] o_sysf, o_state;
    int o_reads, o_writes, o_fin;

    task automatic run_op(input logic [ADDR_W-1:0] a, input logic [7:0] t, input logic [63:0] d);
        int cyc;
        int r0, w0;
        r0 = n_reads;
        w0 = n_writes;
        o_fin = 0;
        @(negedge clk);
        execute_address = a;
        execute_tag = t;
        execute_data = d;
        execute_start = 1'b1;
        cyc = 0;
        while (!finished && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        // Keep start high a while: finished must not repeat and no new op may begin.
        for (int i = 0; i < 4; i++) begin
            if (finished) o_fin++;
            @(negedge clk);
        end
        o_err = error;
        o_sysf = ret_sysf;
        o_state = ret_state;
        execute_start = 1'b0;
        repeat (3) @(negedge clk);
        o_reads = n_reads - r0;
        o_writes = n_writes - w0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs %h want 0", outs());
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs %h want 0", outs());
        end
    endtask

    task automatic test_constant();
        mem[1] = {8'h00, 28'd3, 28'd2};
        mem[2] = {8'h03, 28'd1, 28'd42};
        mem[3] = {8'h03, 28'd8, 28'd9};
        run_op(10'd1, 8'h00, mem[1]);
        n_checks++;
        if ({o_err, o_sysf, o_state} !== {8'd0, 4'h1, 4'h0}) begin
            n_fail++;
            $display("FAIL const_ret: err/sysf/state %h/%h/%h want 0/1/0", o_err, o_sysf, o_state);
        end
        n_checks++;
        if (mem[1] !== {8'h82, 28'd42, 28'd0}) begin
            n_fail++;
            $display("FAIL const_word: got %h want %h", mem[1], {8'h82, 28'd42, 28'd0});
        end
        n_checks++;
        if (o_reads != 1 || o_writes != 1 || o_fin != 1) begin
            n_fail++;
            $display("FAIL const_acc: reads/writes/fin %0d/%0d/%0d want 1/1/1",
                     o_reads, o_writes, o_fin);
        end
    endtask

    task automatic test_slot_axis1();
        mem[1] = {8'h02, 28'd7, 28'd2};
        mem[2] = {8'h03, 28'd0, 28'd1};
        run_op(10'd1, 8'h02, mem[1]);
        n_checks++;
        if ({o_err, o_sysf, o_state} !== {8'd0, 4'h1, 4'h0}) begin
            n_fail++;
            $display("FAIL axis1_ret: err/sysf/state %h/%h/%h want 0/1/0", o_err, o_sysf, o_state);
        end
        n_checks++;
        if (mem[1] !== {8'h82, 28'd7, 28'd0}) begin
            n_fail++;
            $display("FAIL axis1_word: got %h want %h", mem[1], {8'h82, 28'd7, 28'd0});
        end
        n_checks++;
        if (o_reads != 1 || o_writes != 1 || o_fin != 1) begin
            n_fail++;
            $display("FAIL axis1_acc: reads/writes/fin %0d/%0d/%0d want 1/1/1",
                     o_reads, o_writes, o_fin);
        end
    endtask

    task automatic test_slot_deep();
        int r0;
        mem[1] = {8'h00, 28'd3, 28'd2};
        mem[2] = {8'h03, 28'd0, 28'd6};
        mem[3] = {8'h02, 28'd5, 28'd4};
        mem[4] = {8'h03, 28'd6, 28'd9};
        r0 = n_reads;
        run_op(10'd1, 8'h00, mem[1]);
        n_checks++;
        if ({o_err, o_sysf, o_state} !== {8'd0, 4'h1, 4'h0}) begin
            n_fail++;
            $display("FAIL deep_ret: err/sysf/state %h/%h/%h want 0/1/0", o_err, o_sysf, o_state);
        end
        n_checks++;
        if (mem[1] !== {8'h82, 28'd6, 28'd0}) begin
            n_fail++;
            $display("FAIL deep_word: got %h want %h", mem[1], {8'h82, 28'd6, 28'd0});
        end
        n_checks++;
        if (o_reads != 3 || o_writes != 1 || o_fin != 1) begin
            n_fail++;
            $display("FAIL deep_acc: reads/writes/fin %0d/%0d/%0d want 3/1/1",
                     o_reads, o_writes, o_fin);
        end
        n_checks++;
        if (rd_log[r0] != 2 || rd_log[r0+1] != 3 || rd_log[r0+2] != 4) begin
            n_fail++;
            $display("FAIL deep_order: read addrs %0d,%0d,%0d want 2,3,4",
                     rd_log[r0], rd_log[r0+1], rd_log[r0+2]);
        end
    endtask

    task automatic test_errors();
        logic [7:0]  tg [7];
        logic [63:0] fw [7];
        int          ee [7];
        int          er [7];
        tg = '{8'h00, 8'h02, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
        fw = '{{8'h03, 28'd7, 28'd5}, {8'h03, 28'd0, 28'd2}, {8'h03, 28'd0, 28'd0},
               {8'h03, 28'd1, 28'd5}, {8'h01, 28'd1, 28'd5}, {8'h02, 28'd0, 28'd2},
               {8'h03, 28'd0, 28'd4}};
        ee = '{2, 3, 3, 1, 1, 3, 3};
        er = '{1, 1, 1, 0, 1, 1, 2};
        mem[3] = {8'h03, 28'd5, 28'd6};
        for (int c = 0; c < 7; c++) begin
            mem[1] = 64'hDEAD_BEEF_0123_4567;
            mem[2] = fw[c];
            run_op(10'd1, tg[c], {tg[c], (tg[c][1] ? 28'd7 : 28'd3), 28'd2});
            n_checks++;
            if ({o_err, o_sysf, o_state} !== {8'(ee[c]), 4'hF, 4'h0}) begin
                n_fail++;
                $display("FAIL err%0d_ret: err/sysf/state %h/%h/%h want %h/f/0",
                         c, o_err, o_sysf, o_state, ee[c]);
            end
            n_checks++;
            if (mem[1] !== 64'hDEAD_BEEF_0123_4567) begin
                n_fail++;
                $display("FAIL err%0d_nowrite: cell %h want dead_beef_0123_4567", c, mem[1]);
            end
            n_checks++;
            if (o_reads != er[c] || o_writes != 0 || o_fin != 1) begin
                n_fail++;
                $display("FAIL err%0d_acc: reads/writes/fin %0d/%0d/%0d want %0d/0/1",
                         c, o_reads, o_writes, o_fin, er[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        mem[1] = {8'h00, 28'd3, 28'd2};
        mem[2] = {8'h03, 28'd7, 28'd5};
        run_op(10'd1, 8'h00, mem[1]);
        n_checks++;
        if ({error, ret_sysf} !== {8'd2, 4'hF}) begin
            n_fail++;
            $display("FAIL held_err: err/sysf %h/%h want 2/f", error, ret_sysf);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL rst_done: outputs %h want 0", outs());
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem[2] = {8'h03, 28'd1, 28'd42};
        @(negedge clk);
        execute_address = 10'd1;
        execute_tag = 8'h00;
        execute_data = mem[1];
        execute_start = 1'b1;
        cyc = 0;
        while (!bus.mem_execute && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (bus.mem_execute !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_strobe: mem_execute %b want 1", bus.mem_execute);
        end
        #1 rst = 1'b1;
        execute_start = 1'b0;
        #1;
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL rst_waitf: outputs %h want 0", outs());
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (mem[1] !== {8'h00, 28'd3, 28'd2}) begin
            n_fail++;
            $display("FAIL rst_nowrite: cell %h want %h", mem[1], {8'h00, 28'd3, 28'd2});
        end
        run_op(10'd1, 8'h00, mem[1]);
        n_checks++;
        if ({o_err, o_sysf, o_state} !== {8'd0, 4'h1, 4'h0}) begin
            n_fail++;
            $display("FAIL restart_ret: err/sysf/state %h/%h/%h want 0/1/0",
                     o_err, o_sysf, o_state);
        end
        n_checks++;
        if (mem[1] !== {8'h82, 28'd42, 28'd0}) begin
            n_fail++;
            $display("FAIL restart_word: got %h want %h", mem[1], {8'h82, 28'd42, 28'd0});
        end
    endtask

    function automatic logic [63:0] rand_node();
        logic ha, ta;
        logic [27:0] h, t;
        ha = ($urandom_range(0, 3) == 0);
        ta = ($urandom_range(0, 3) == 0);
        h = ha ? 28'($urandom_range(0, 1000)) : 28'(100 + $urandom_range(0, 31));
        t = ta ? 28'($urandom_range(0, 1000)) : 28'(100 + $urandom_range(0, 31));
        return {6'd0, ha, ta, h, t};
    endfunction

    task automatic test_random();
        int          e, rd, r;
        logic [63:0] want, old, cdata;
        logic [7:0]  ctag, ftag;
        logic [27:0] op, ftail, subj;
        logic        sa;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 32; k++) mem[100 + k] = rand_node();
            r = int'($urandom_range(0, 9));
            ftag = 8'h03;
            ftail = 28'($urandom_range(0, 40));
            if (r <= 5) op = 28'd0;
            else if (r <= 7) begin
                op = 28'd1;
                ftag = {7'd1, 1'($urandom_range(0, 1))};
                ftail = 28'($urandom_range(0, 100000));
            end else if (r == 8) op = 28'($urandom_range(2, 9));
            else begin
                op = 28'($urandom_range(0, 1));
                ftag = 8'($urandom_range(0, 3));
            end
            mem[20] = {ftag, op, ftail};
            sa = ($urandom_range(0, 3) == 0);
            subj = sa ? 28'($urandom_range(0, 500)) : 28'(100 + $urandom_range(0, 31));
            ctag = {6'd0, sa, (it % 13 == 5)};
            cdata = {ctag, subj, 28'd20};
            mem[10] = cdata;
            old = cdata;
            lat_extra = int'($urandom_range(0, 2));
            ref_model(ctag, cdata, e, want, rd);
            run_op(10'd10, ctag, cdata);
            n_checks++;
            if ({o_err, o_sysf, o_state} !== {8'(e), (e == 0) ? 4'h1 : 4'hF, 4'h0}) begin
                n_fail++;
                $display("FAIL rnd%0d_ret: err/sysf/state %h/%h/%h want %h/%h/0",
                         it, o_err, o_sysf, o_state, e, (e == 0) ? 4'h1 : 4'hF);
            end
            n_checks++;
            if (mem[10] !== ((e == 0) ? want : old)) begin
                n_fail++;
                $display("FAIL rnd%0d_word: got %h want %h", it, mem[10],
                         (e == 0) ? want : old);
            end
            n_checks++;
            if (o_reads != rd || o_writes != ((e == 0) ? 1 : 0) || o_fin != 1) begin
                n_fail++;
                $display("FAIL rnd%0d_acc: reads/writes/fin %0d/%0d/%0d want %0d/%0d/1",
                         it, o_reads, o_writes, o_fin, rd, (e == 0) ? 1 : 0);
            end
        end
        lat_extra = 0;
        n_checks++;
        if (n_proto != 0) begin
            n_fail++;
            $display("FAIL handshake: %0d protocol violations want 0", n_proto);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        n_reads = 0;
        n_writes = 0;
        n_proto = 0;
        lat_extra = 0;
        pend_cnt = 0;
        rst = 1'b1;
        execute_start = 1'b0;
        execute_address = '0;
        execute_tag = '0;
        execute_data = '0;
        bus.free_addr = 10'd500;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_constant();
        test_slot_axis1();
        test_slot_deep();
        test_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
